bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Arbitrates the shared 256-bit system bus between two masters: M0, the execution engine, and M1, the program/data loader or debug port.
- Decodes the 16-bit address into one-hot slave selects: main memory, int ALU, matrix ALU and instruction memory.
- Drives the active-low nRead/nWrite strobes for a fixed number of cycles and returns the selected slave's read data to the granted master with a one-cycle ack.

Parameters:
- ACCESS_LATENCY, 2: cycles strobes are held low before data is sampled or the write completes; legal range 1..15.
- DATA_W, 256: data bus width.
- ADDR_W, 16: address width.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- nReset  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  master request; held high until that master's ack.
- m0_nRead, m1_nRead  in  1  active-low read request qualifier.
- m0_nWrite, m1_nWrite  in  1  active-low write request qualifier.
- m0_address, m1_address  in  16  target address.
- m0_wdata, m1_wdata  in  256  write data.
- m0_gnt, m1_gnt  out  1  master owns the bus.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  valid with ack; decode or protocol error.
- m0_rdata, m1_rdata  out  256  read data, valid from ack onward until that master's next ack.
- nRead, nWrite  out  1  shared bus strobes.
- address  out  16  shared bus address.
- ExeDataOut  out  256  shared bus write data.
- slave_sel  out  4  one-hot select: [0] main memory, [1] int ALU, [2] matrix ALU, [3] instruction memory.
- MemDataOut, IntDataOut, MatrixDataOut, InstructDataOut  in  256  slave read data.

Behaviour:
- Reset (async, nReset=0):
  - nRead=1, nWrite=1, address=0, ExeDataOut=0, slave_sel=0.
  - All gnt/ack/err=0; all rdata=0.
  - state=IDLE, cnt=0, last=1, so M0 wins the first tie.
  - Reset mid-transaction aborts it: strobes rise immediately and no ack is issued.
- Address map:
  - 0x0000-0x0FFF: main memory.
  - 0x1000-0x1FFF: int ALU.
  - 0x2000-0x2FFF: matrix ALU.
  - 0x8000-0xFFFF: instruction memory.
  - Any other address is a decode error.
- States: IDLE, BUS, DONE.
- IDLE:
  - Only one req high: grant that master.
  - Both high: grant the master not equal to last (round-robin).
  - On the grant edge, all of the following are registered: gnt=1, address, ExeDataOut=wdata (writes only), slave_sel, strobes. The master number is stored in last. cnt=1. Next state is BUS.
- Strobes in BUS:
  - Read (nRead=0, nWrite=1): nRead=0.
  - Write (nRead=1, nWrite=0): nWrite=0.
- Protocol or decode error: both qualifiers low, both high, or an unmapped address.
  - Strobes stay 1 and slave_sel=0.
  - The transaction still runs the full latency, then acks with err=1.
- BUS:
  - Each edge with cnt<ACCESS_LATENCY: cnt++.
  - Edge with cnt==ACCESS_LATENCY:
    - Reads: rdata of the granted master <= the selected slave's data; erroring reads leave rdata unchanged.
    - ack=1, err as decoded.
    - nRead=1, nWrite=1, slave_sel=0, ExeDataOut=0.
    - Next state is DONE.
- DONE (one turnaround cycle): on the next edge ack=0, err=0, gnt=0; next state is IDLE.
- Timing: if the grant edge is t0, ack is high during the cycle after edge t0+L, where L=ACCESS_LATENCY. The earliest next grant is edge t0+L+2. Throughput is one transfer per L+2 cycles.
- Transactions are non-abortable: if req drops during BUS, the transaction completes and ack is still pulsed.
- Master inputs are sampled only on the grant edge; later changes are ignored.
- A master holding req after its ack starts a new transaction. With both masters requesting continuously, grants alternate M0, M1, M0, and so on.
- No reply from a deselected slave is used; the rdata mux is driven from the registered slave_sel.

Decomposition:
- Package bus_pkg:
  - state enum {IDLE, BUS, DONE}.
  - Region base/limit constants and the slave index constants SEL_MEM, SEL_INT, SEL_MAT, SEL_INS.
  - Default latency.
- Sub-module bus_addr_decode: combinational; address -> one-hot slave_sel plus decode_err. Shared later with the execution engine's bench.

Test Plan:
- Single M0 read of 0x0004 with MemDataOut=0x1234, L=2: grant edge t0; nRead=0 and slave_sel=0001 during t0..t0+2; m0_ack pulses after edge t0+2; m0_rdata=0x1234; m0_err=0.
- M1 write of 0x2011 with wdata=0xABCD: nWrite=0 for 2 cycles, slave_sel=0100, ExeDataOut=0xABCD, address=0x2011; m1_ack pulses; nRead stays 1 throughout.
- Both masters request continuously from reset: grant order M0, M1, M0, M1; each grant starts 4 cycles after the previous grant edge; ack never overlaps between masters.
- M0 read of 0x4000 (unmapped): strobes stay 1, slave_sel=0; m0_ack with m0_err=1 after 2 cycles; m0_rdata keeps its previous value.
- Reset during BUS at cycle t0+1: nRead=1 and gnt=0 immediately; no ack; the first post-reset request from both masters is granted to M0.
- M0 drops req one cycle after grant: transaction still completes and m0_ack pulses after edge t0+2; IDLE follows and no second grant is issued.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the system bus arbiter.
// Imported by the arbiter, its address decoder and test benches.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BUS_DATA_W  = 256;
    localparam int BUS_ADDR_W  = 16;
    localparam int DEF_LATENCY = 2;
    localparam int SLV_N       = 4;

    localparam int SEL_MEM = 0;
    localparam int SEL_INT = 1;
    localparam int SEL_MAT = 2;
    localparam int SEL_INS = 3;

    localparam logic [15:0] MEM_BASE  = 16'h0000;
    localparam logic [15:0] MEM_LIMIT = 16'h0FFF;
    localparam logic [15:0] INT_BASE  = 16'h1000;
    localparam logic [15:0] INT_LIMIT = 16'h1FFF;
    localparam logic [15:0] MAT_BASE  = 16'h2000;
    localparam logic [15:0] MAT_LIMIT = 16'h2FFF;
    localparam logic [15:0] INS_BASE  = 16'h8000;
    localparam logic [15:0] INS_LIMIT = 16'hFFFF;

    // Every data region is exactly one 4 KiB page, so the top nibble
    // of the base address identifies it.
    localparam logic [3:0] MEM_PAGE = MEM_BASE[15:12];
    localparam logic [3:0] INT_PAGE = INT_BASE[15:12];
    localparam logic [3:0] MAT_PAGE = MAT_BASE[15:12];

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: address to one-hot slave select.
// Unmapped addresses give an all-zero select and decode error.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [SLV_N-1:0]  o_sel,
    output logic              o_err
);

    logic [3:0] w_page;

    assign w_page = i_addr[ADDR_W-1 -: 4];

    // Instruction memory owns the upper half; data regions are single pages.
    always_comb begin
        o_sel = '0;
        unique case (1'b1)
            w_page[3]:              o_sel[SEL_INS] = 1'b1;
            (w_page == MEM_PAGE):   o_sel[SEL_MEM] = 1'b1;
            (w_page == INT_PAGE):   o_sel[SEL_INT] = 1'b1;
            (w_page == MAT_PAGE):   o_sel[SEL_MAT] = 1'b1;
            default:                o_sel = '0;
        endcase
    end

    assign o_err = ~|o_sel;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared system bus.
// Holds strobes for a fixed latency, then acks the owner for one cycle.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ACCESS_LATENCY = DEF_LATENCY,
    parameter int DATA_W         = BUS_DATA_W,
    parameter int ADDR_W         = BUS_ADDR_W
) (
    input  logic              Clk,
    input  logic              nReset,

    input  logic              m0_req,
    input  logic              m0_nRead,
    input  logic              m0_nWrite,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_nRead,
    input  logic              m1_nWrite,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              nRead,
    output logic              nWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] ExeDataOut,
    output logic [SLV_N-1:0]  slave_sel,

    input  logic [DATA_W-1:0] MemDataOut,
    input  logic [DATA_W-1:0] IntDataOut,
    input  logic [DATA_W-1:0] MatrixDataOut,
    input  logic [DATA_W-1:0] InstructDataOut
);

    localparam logic [3:0] LAT = 4'(ACCESS_LATENCY);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_last;
    logic                r_rd_pend;
    logic                r_err_pend;

    logic                r_m0_gnt;
    logic                r_m0_ack;
    logic                r_m0_err;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic                r_m1_gnt;
    logic                r_m1_ack;
    logic                r_m1_err;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic                r_nread;
    logic                r_nwrite;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_exe;
    logic [SLV_N-1:0]    r_sel;

    logic                w_any;
    logic                w_pick_m1;
    logic                w_nrd;
    logic                w_nwr;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [SLV_N-1:0]    w_sel;
    logic                w_dec_err;
    logic                w_is_rd;
    logic                w_is_wr;
    logic                w_bad;
    logic [DATA_W-1:0]   w_slave_rdata;

    assign w_any     = m0_req | m1_req;
    assign w_pick_m1 = m1_req & (~m0_req | ~r_last);

    assign w_nrd   = w_pick_m1 ? m1_nRead   : m0_nRead;
    assign w_nwr   = w_pick_m1 ? m1_nWrite  : m0_nWrite;
    assign w_addr  = w_pick_m1 ? m1_address : m0_address;
    assign w_wdata = w_pick_m1 ? m1_wdata   : m0_wdata;

    bus_addr_decode #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .i_addr (w_addr),
        .o_sel  (w_sel),
        .o_err  (w_dec_err)
    );

    assign w_is_rd = ~w_nrd &  w_nwr;
    assign w_is_wr =  w_nrd & ~w_nwr;
    assign w_bad   = w_dec_err | ~(w_is_rd | w_is_wr);

    // Read-data return path follows the registered select only.
    always_comb begin
        w_slave_rdata = '0;
        unique case (1'b1)
            r_sel[SEL_MEM]: w_slave_rdata = MemDataOut;
            r_sel[SEL_INT]: w_slave_rdata = IntDataOut;
            r_sel[SEL_MAT]: w_slave_rdata = MatrixDataOut;
            r_sel[SEL_INS]: w_slave_rdata = InstructDataOut;
            default:        w_slave_rdata = '0;
        endcase
    end

    // Grant, access-latency count, ack and turnaround sequencing.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last     <= 1'b1;
            r_rd_pend  <= 1'b0;
            r_err_pend <= 1'b0;
            r_m0_gnt   <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_gnt   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m1_err   <= 1'b0;
            r_m1_rdata <= '0;
            r_nread    <= 1'b1;
            r_nwrite   <= 1'b1;
            r_address  <= '0;
            r_exe      <= '0;
            r_sel      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state    <= BUS;
                        r_cnt      <= 4'd1;
                        r_last     <= w_pick_m1;
                        r_m0_gnt   <= ~w_pick_m1;
                        r_m1_gnt   <= w_pick_m1;
                        r_address  <= w_addr;
                        r_sel      <= w_bad ? '0 : w_sel;
                        r_nread    <= ~(w_is_rd & ~w_bad);
                        r_nwrite   <= ~(w_is_wr & ~w_bad);
                        r_exe      <= (w_is_wr & ~w_bad) ? w_wdata : '0;
                        r_rd_pend  <= w_is_rd & ~w_bad;
                        r_err_pend <= w_bad;
                    end
                end
                BUS: begin
                    if (r_cnt < LAT) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        if (r_rd_pend) begin
                            if (r_last) begin
                                r_m1_rdata <= w_slave_rdata;
                            end else begin
                                r_m0_rdata <= w_slave_rdata;
                            end
                        end
                        r_m0_ack <= ~r_last;
                        r_m1_ack <= r_last;
                        r_m0_err <= ~r_last & r_err_pend;
                        r_m1_err <= r_last & r_err_pend;
                        r_nread  <= 1'b1;
                        r_nwrite <= 1'b1;
                        r_sel    <= '0;
                        r_exe    <= '0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_m0_err <= 1'b0;
                    r_m1_err <= 1'b0;
                    r_m0_gnt <= 1'b0;
                    r_m1_gnt <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m0_gnt     = r_m0_gnt;
    assign m0_ack     = r_m0_ack;
    assign m0_err     = r_m0_err;
    assign m0_rdata   = r_m0_rdata;
    assign m1_gnt     = r_m1_gnt;
    assign m1_ack     = r_m1_ack;
    assign m1_err     = r_m1_err;
    assign m1_rdata   = r_m1_rdata;
    assign nRead      = r_nread;
    assign nWrite     = r_nwrite;
    assign address    = r_address;
    assign ExeDataOut = r_exe;
    assign slave_sel  = r_sel;

endmodule
